// File: rtl/ram_loader.sv
// RAM loader: streams bytes into the CPU's 256x8 RAM through the MAR/write-strobe
// interface, with an optional read-back pass that compares additive checksums.
module ram_loader #(
  parameter logic [7:0] BASE_ADDR      = 8'h00,
  parameter bit         VERIFY_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] length,
  input  logic       verify_en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] ram_bas,
  output logic       ram_wsa,
  output logic [7:0] ram_bis,
  output logic       ram_ws,
  output logic       ram_we,
  input  logic [7:0] ram_bos,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] wr_sum,
  output logic [7:0] rd_sum,
  output logic       cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SETA,
    WR,
    VSETA,
    VRD,
    FIN
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] addr;
  logic [8:0] len_q;
  logic [8:0] remain;
  logic       verify;
  logic [7:0] data_q;
  logic [7:0] wr_sum_q;
  logic [7:0] rd_sum_q;
  logic       err_q;
  logic       last;
  logic       fin_err;

  assign last = (remain == 9'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ram_wsa    = 1'b0;
    ram_ws     = 1'b0;
    ram_we     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (length == 9'd0) ? FIN : FETCH;
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SETA;
      end
      SETA: begin
        ram_wsa    = 1'b1;
        state_next = WR;
      end
      WR: begin
        ram_ws = 1'b1;
        if (last) state_next = verify ? VSETA : FIN;
        else      state_next = FETCH;
      end
      VSETA: begin
        ram_wsa    = 1'b1;
        state_next = VRD;
      end
      VRD: begin
        ram_we     = 1'b1;
        state_next = last ? FIN : VSETA;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The byte counter is reloaded at the last write so the verify pass reuses it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr     <= BASE_ADDR;
      len_q    <= 9'd0;
      remain   <= 9'd0;
      verify   <= VERIFY_DEFAULT;
      data_q   <= 8'h00;
      wr_sum_q <= 8'h00;
      rd_sum_q <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= length;
            remain   <= length;
            verify   <= verify_en;
            addr     <= BASE_ADDR;
            wr_sum_q <= 8'h00;
            rd_sum_q <= 8'h00;
            err_q    <= 1'b0;
          end
        end
        FETCH: begin
          if (in_valid) begin
            data_q   <= in_data;
            wr_sum_q <= wr_sum_q + in_data;
          end
        end
        WR: begin
          if (last) begin
            addr   <= BASE_ADDR;
            remain <= len_q;
          end else begin
            addr   <= addr + 8'd1;
            remain <= remain - 9'd1;
          end
        end
        VRD: begin
          rd_sum_q <= rd_sum_q + ram_bos;
          if (!last) begin
            addr   <= addr + 8'd1;
            remain <= remain - 9'd1;
          end
        end
        FIN: err_q <= fin_err;
        default: ;
      endcase
    end
  end

  // error is visible during the done cycle and then held by err_q.
  assign fin_err  = (state == FIN) && verify && (wr_sum_q != rd_sum_q);
  assign error    = err_q | fin_err;
  assign ram_bas  = ram_wsa ? addr : 8'h00;
  assign ram_bis  = ram_ws ? data_q : 8'h00;
  assign busy     = (state != IDLE);
  assign cpu_hold = busy;
  assign wr_sum   = wr_sum_q;
  assign rd_sum   = rd_sum_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: two instances (base 00 and base FE), each with a
// behavioural MAR/RAM model that responds to the loader's strobes.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start0, start1;
  logic [8:0] length;
  logic       verify_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       corrupt;

  logic       in_ready0, ram_wsa0, ram_ws0, ram_we0, busy0, done0, error0, cpu_hold0;
  logic [7:0] ram_bas0, ram_bis0, ram_bos0, wr_sum0, rd_sum0;
  logic       in_ready1, ram_wsa1, ram_ws1, ram_we1, busy1, done1, error1, cpu_hold1;
  logic [7:0] ram_bas1, ram_bis1, ram_bos1, wr_sum1, rd_sum1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int bus_viol = 0;
  int strobes0 = 0;
  int busy_cyc0 = 0;
  int done_cnt0 = 0;
  int lat;
  int snap_busy, snap_strobe;

  logic [7:0] stream [12];
  logic [7:0] add_prog [12];
  logic [7:0] mem0 [256] = '{default: 8'h00};
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] mar0 = 8'h00;
  logic [7:0] mar1 = 8'h00;

  always #5 clk = ~clk;

  ram_loader #(.BASE_ADDR(8'h00), .VERIFY_DEFAULT(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .length(length), .verify_en(verify_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .ram_bas(ram_bas0), .ram_wsa(ram_wsa0), .ram_bis(ram_bis0), .ram_ws(ram_ws0),
    .ram_we(ram_we0), .ram_bos(ram_bos0), .busy(busy0), .done(done0), .error(error0),
    .wr_sum(wr_sum0), .rd_sum(rd_sum0), .cpu_hold(cpu_hold0)
  );

  ram_loader #(.BASE_ADDR(8'hFE), .VERIFY_DEFAULT(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .length(length), .verify_en(verify_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .ram_bas(ram_bas1), .ram_wsa(ram_wsa1), .ram_bis(ram_bis1), .ram_ws(ram_ws1),
    .ram_we(ram_we1), .ram_bos(ram_bos1), .busy(busy1), .done(done1), .error(error1),
    .wr_sum(wr_sum1), .rd_sum(rd_sum1), .cpu_hold(cpu_hold1)
  );

  // RAM models: MAR loads on its strobe, write lands at the MAR, read is combinational.
  always @(posedge clk) begin
    if (ram_wsa0) mar0 <= ram_bas0;
    if (ram_ws0)  mem0[mar0] <= ram_bis0;
    if (corrupt)  mem0[5] <= 8'h00;
    if (ram_wsa1) mar1 <= ram_bas1;
    if (ram_ws1)  mem1[mar1] <= ram_bis1;
  end

  assign ram_bos0 = ram_we0 ? mem0[mar0] : 8'h00;
  assign ram_bos1 = ram_we1 ? mem1[mar1] : 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus-rule watcher, sampled just after each falling edge.
  always @(negedge clk) begin
    #1;
    if (int'(ram_wsa0) + int'(ram_ws0) + int'(ram_we0) > 1) bus_viol++;
    if (int'(ram_wsa1) + int'(ram_ws1) + int'(ram_we1) > 1) bus_viol++;
    if (!ram_wsa0 && ram_bas0 != 8'h00) bus_viol++;
    if (!ram_ws0 && ram_bis0 != 8'h00) bus_viol++;
    if (!ram_wsa1 && ram_bas1 != 8'h00) bus_viol++;
    if (!ram_ws1 && ram_bis1 != 8'h00) bus_viol++;
    if (cpu_hold0 != busy0 || cpu_hold1 != busy1) bus_viol++;
    if (ram_wsa0 || ram_ws0 || ram_we0) strobes0++;
    if (busy0) busy_cyc0++;
    if (done0) done_cnt0++;
  end

  function automatic logic rdy(input bit sel);
    return sel ? in_ready1 : in_ready0;
  endfunction

  function automatic logic [2:0] strobes(input bit sel);
    return sel ? {ram_wsa1, ram_ws1, ram_we1} : {ram_wsa0, ram_ws0, ram_we0};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit sel, input logic [8:0] len, input logic ven);
    @(negedge clk);
    length    = len;
    verify_en = ven;
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_bytes(input bit sel, input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) begin
      int k = 0;
      in_data  = stream[i];
      in_valid = (gap == 0);
      while (!rdy(sel) && k < 50) begin
        @(negedge clk);
        k++;
      end
      check_output($sformatf("ready_%0d", i), 64'(rdy(sel)), 64'd1);
      for (int g = 0; g < gap; g++) begin
        check_output($sformatf("gap_%0d_%0d", i, g), 64'({rdy(sel), strobes(sel)}), 64'h8);
        @(negedge clk);
      end
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int limit, output int latency);
    int k = 0;
    while (!(sel ? done1 : done0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_output("done_seen", 64'(sel ? done1 : done0), 64'd1);
    latency = cyc - start_cyc;
  endtask

  initial begin
    reset_n   = 1'b0;
    start0    = 1'b0;
    start1    = 1'b0;
    length    = 9'd0;
    verify_en = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    corrupt   = 1'b0;
    add_prog  = '{8'h20, 8'h00, 8'h7C, 8'h20, 8'h14, 8'h78,
                  8'h21, 8'h16, 8'h79, 8'h81, 8'h79, 8'h61};
    repeat (3) @(negedge clk);
    check_output("reset_dut0", 64'({in_ready0, ram_bas0, ram_wsa0, ram_bis0, ram_ws0, ram_we0,
                 busy0, done0, error0, wr_sum0, rd_sum0, cpu_hold0}), 64'd0);
    check_output("reset_dut1", 64'({in_ready1, ram_bas1, ram_wsa1, ram_bis1, ram_ws1, ram_we1,
                 busy1, done1, error1, wr_sum1, rd_sum1, cpu_hold1}), 64'd0);
    reset_n = 1'b1;

    // ADD program, verify on, valid held high
    stream = add_prog;
    apply_stimulus(1'b0, 9'd12, 1'b1);
    send_bytes(1'b0, 0, 12, 0);
    wait_done(1'b0, 200, lat);
    check_output("add_latency", 64'(lat), 64'd61);
    check_output("add_wr_sum", 64'(wr_sum0), 64'h53);
    check_output("add_rd_sum", 64'(rd_sum0), 64'h53);
    check_output("add_error", 64'(error0), 64'd0);
    for (int i = 0; i < 12; i++)
      check_output($sformatf("add_ram_%0d", i), 64'(mem0[i]), 64'(add_prog[i]));
    @(negedge clk);
    check_output("add_idle_after", 64'({busy0, done0}), 64'd0);

    // Same load with five idle cycles before every byte
    apply_stimulus(1'b0, 9'd12, 1'b1);
    send_bytes(1'b0, 0, 12, 5);
    wait_done(1'b0, 400, lat);
    check_output("gap_latency", 64'(lat), 64'd121);
    check_output("gap_wr_sum", 64'(wr_sum0), 64'h53);
    check_output("gap_rd_sum", 64'(rd_sum0), 64'h53);
    check_output("gap_error", 64'(error0), 64'd0);
    for (int i = 0; i < 12; i++)
      check_output($sformatf("gap_ram_%0d", i), 64'(mem0[i]), 64'(add_prog[i]));

    // RAM[5] zeroed after the last write, before read-back
    apply_stimulus(1'b0, 9'd12, 1'b1);
    send_bytes(1'b0, 0, 12, 0);
    @(negedge clk);
    check_output("corrupt_in_wr", 64'(ram_ws0), 64'd1);
    corrupt = 1'b1;
    @(negedge clk);
    corrupt = 1'b0;
    wait_done(1'b0, 200, lat);
    check_output("corrupt_latency", 64'(lat), 64'd61);
    check_output("corrupt_wr_sum", 64'(wr_sum0), 64'h53);
    check_output("corrupt_rd_sum", 64'(rd_sum0), 64'hDB);
    check_output("corrupt_error_at_done", 64'(error0), 64'd1);
    repeat (3) @(negedge clk);
    check_output("corrupt_error_held", 64'({error0, busy0}), 64'b10);

    // Zero-length load
    snap_busy   = busy_cyc0;
    snap_strobe = strobes0;
    apply_stimulus(1'b0, 9'd0, 1'b1);
    check_output("len0_done", 64'({done0, busy0}), 64'b11);
    check_output("len0_latency", 64'(cyc - start_cyc), 64'd1);
    check_output("len0_error", 64'(error0), 64'd0);
    check_output("len0_sums", 64'({wr_sum0, rd_sum0}), 64'd0);
    repeat (2) @(negedge clk);
    check_output("len0_busy_cycles", 64'(busy_cyc0 - snap_busy), 64'd1);
    check_output("len0_strobes", 64'(strobes0 - snap_strobe), 64'd0);

    // Reset during the write of the third byte
    stream[0:4] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply_stimulus(1'b0, 9'd5, 1'b0);
    send_bytes(1'b0, 0, 3, 0);
    @(negedge clk);
    check_output("abort_in_wr", 64'(ram_ws0), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("abort_outputs", 64'({in_ready0, ram_bas0, ram_wsa0, ram_bis0, ram_ws0, ram_we0,
                 busy0, done0, error0, wr_sum0, rd_sum0, cpu_hold0}), 64'd0);
    reset_n = 1'b1;
    check_output("abort_ram_0", 64'(mem0[0]), 64'h11);
    check_output("abort_ram_1", 64'(mem0[1]), 64'h22);
    check_output("abort_ram_2", 64'(mem0[2]), 64'h33);
    check_output("abort_ram_3", 64'(mem0[3]), 64'h20);

    // Two-byte load with a stray start while busy
    stream[0:1] = '{8'h5A, 8'hA5};
    apply_stimulus(1'b0, 9'd2, 1'b1);
    send_bytes(1'b0, 0, 1, 0);
    length = 9'd7;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    send_bytes(1'b0, 1, 1, 0);
    wait_done(1'b0, 100, lat);
    check_output("two_latency", 64'(lat), 64'd11);
    check_output("two_sums", 64'({wr_sum0, rd_sum0}), 64'hFFFF);
    check_output("two_error", 64'(error0), 64'd0);
    check_output("two_ram", 64'({mem0[0], mem0[1], mem0[2]}), 64'h5AA533);
    repeat (3) @(negedge clk);
    check_output("two_idle_after", 64'(busy0), 64'd0);

    // Base FE wraps through FF to 00
    stream[0:3] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    apply_stimulus(1'b1, 9'd4, 1'b1);
    send_bytes(1'b1, 0, 4, 0);
    wait_done(1'b1, 100, lat);
    check_output("wrap_latency", 64'(lat), 64'd21);
    check_output("wrap_sums", 64'({wr_sum1, rd_sum1}), 64'h0E0E);
    check_output("wrap_error", 64'(error1), 64'd0);
    check_output("wrap_ram", 64'({mem1[8'hFE], mem1[8'hFF], mem1[8'h00], mem1[8'h01], mem1[8'h02]}),
                 64'hAABBCCDD00);

    repeat (2) @(negedge clk);
    check_output("done_pulses_dut0", 64'(done_cnt0), 64'd5);
    check_output("bus_rules", 64'(bus_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
